// File: rtl/sha256_block_loader_if.sv
// Bus bundle between the SHA-256 block loader, the shared word memory and the compression stage.
// master = loader side; slave = memory read port plus block consumer.
interface sha256_block_loader_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              mem_clk;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_read_data;
    logic              blk_valid;
    logic              blk_ready;
    logic [511:0]      blk_data;
    logic [5:0]        blk_idx;
    logic              blk_last;

    modport master (
        output mem_clk, mem_we, mem_addr, blk_valid, blk_data, blk_idx, blk_last,
        input  mem_read_data, blk_ready
    );

    modport slave (
        input  mem_clk, mem_we, mem_addr, blk_valid, blk_data, blk_idx, blk_last,
        output mem_read_data, blk_ready
    );
endinterface

// File: rtl/sha256_block_loader.sv
// Fetches a NUM_OF_WORDS-word message, applies SHA-256 padding and presents 512-bit blocks.
// Optional SHA256_BYTE_SWAP_EN: byte-reverse each fetched message word (little-endian images).
module sha256_block_loader #(
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     message_addr,
    output logic                  done,
    sha256_block_loader_if.master bus
);
    localparam int unsigned    NB        = (NUM_OF_WORDS + 2) / 16 + 1;
    localparam int unsigned    P_W       = 12;
    localparam int unsigned    B_W       = 7;
    localparam logic [P_W-1:0] P_MSG_END = P_W'(NUM_OF_WORDS);
    localparam logic [P_W-1:0] P_LEN_LO  = P_W'(16 * NB - 1);
    localparam logic [31:0]    LEN_BITS  = 32'(32 * NUM_OF_WORDS);
    localparam logic [B_W-1:0] LAST_BLK  = B_W'(NB - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_CAPT, S_PAD, S_OUT} state_t;

    state_t            r_state, w_state_nxt;
    logic [B_W-1:0]    r_blk, w_blk_nxt;
    logic [3:0]        r_slot, w_slot_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic              r_blk_valid, w_blk_valid_nxt;
    logic              r_blk_last, w_blk_last_nxt;
    logic              r_done, w_done_nxt;
    logic [31:0]       r_buf [16];
    logic              w_wr_en;
    logic [31:0]       w_wr_data;
    logic [31:0]       w_fetch_word;
    logic [31:0]       w_pad_word;
    logic [P_W-1:0]    w_p, w_p_inc, w_p_blk_next;

    assign w_p          = P_W'({r_blk, r_slot});
    assign w_p_inc      = w_p + P_W'(1);
    assign w_p_blk_next = P_W'({r_blk + B_W'(1), 4'd0});

`ifdef SHA256_BYTE_SWAP_EN
    assign w_fetch_word = {bus.mem_read_data[7:0],   bus.mem_read_data[15:8],
                           bus.mem_read_data[23:16], bus.mem_read_data[31:24]};
`else
    assign w_fetch_word = bus.mem_read_data;
`endif

    // Padding word for slot p; the high length word is always zero (message < 2^32 bits).
    always_comb begin
        w_pad_word = 32'h0;
        if (w_p == P_MSG_END) begin
            w_pad_word = 32'h8000_0000;
        end else if (w_p == P_LEN_LO) begin
            w_pad_word = LEN_BITS;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt     = r_state;
        w_blk_nxt       = r_blk;
        w_slot_nxt      = r_slot;
        w_base_nxt      = r_base;
        w_mem_addr_nxt  = r_mem_addr;
        w_blk_valid_nxt = r_blk_valid;
        w_blk_last_nxt  = r_blk_last;
        w_wr_en         = 1'b0;
        w_wr_data       = w_fetch_word;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // Message is at least one word long, so slot 0 of block 0 is always fetched
                    w_base_nxt     = message_addr;
                    w_blk_nxt      = '0;
                    w_slot_nxt     = '0;
                    w_mem_addr_nxt = message_addr;
                    w_state_nxt    = S_ADDR;
                end
            end
            S_ADDR: w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_CAPT;
            S_CAPT, S_PAD: begin
                w_wr_en    = 1'b1;
                w_wr_data  = (r_state == S_CAPT) ? w_fetch_word : w_pad_word;
                w_slot_nxt = r_slot + 4'd1;
                if (r_slot == 4'd15) begin
                    w_state_nxt     = S_OUT;
                    w_blk_valid_nxt = 1'b1;
                    w_blk_last_nxt  = (r_blk == LAST_BLK);
                end else if (w_p_inc < P_MSG_END) begin
                    w_state_nxt    = S_ADDR;
                    w_mem_addr_nxt = r_base + ADDR_W'(w_p_inc);
                end else begin
                    w_state_nxt = S_PAD;
                end
            end
            S_OUT: begin
                if (bus.blk_ready) begin
                    w_blk_valid_nxt = 1'b0;
                    if (r_blk_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_blk_nxt  = r_blk + B_W'(1);
                        w_slot_nxt = '0;
                        if (w_p_blk_next < P_MSG_END) begin
                            w_state_nxt    = S_ADDR;
                            w_mem_addr_nxt = r_base + ADDR_W'(w_p_blk_next);
                        end else begin
                            w_state_nxt = S_PAD;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_done_nxt = (w_state_nxt == S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_blk       <= '0;
            r_slot      <= '0;
            r_base      <= '0;
            r_mem_addr  <= '0;
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
            r_done      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_blk       <= w_blk_nxt;
            r_slot      <= w_slot_nxt;
            r_base      <= w_base_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_blk_valid <= w_blk_valid_nxt;
            r_blk_last  <= w_blk_last_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Block buffer: only written in CAPT/PAD, so it is frozen while the block is presented
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_buf[r_slot] <= w_wr_data;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_blk_data
        assign bus.blk_data[511 - 32*g -: 32] = r_buf[g];
    end

    assign bus.mem_clk   = clk;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.blk_valid = r_blk_valid;
    assign bus.blk_idx   = r_blk[5:0];
    assign bus.blk_last  = r_blk_last;
    assign done          = r_done;
endmodule

// File: tb/tb_sha256_block_loader.sv
// Directed bench for sha256_block_loader: four instances (N = 20, 13, 14, 4) sharing one memory image.
module tb_sha256_block_loader;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned ND     = 4;
    localparam int unsigned NW   [ND] = '{20, 13, 14, 4};
    localparam logic [15:0] BASE [ND] = '{16'h0100, 16'h0100, 16'h0100, 16'hFFFE};
`ifdef SHA256_BYTE_SWAP_EN
    localparam logic [31:0] WRAP_W0 = 32'h4433_2211;
`else
    localparam logic [31:0] WRAP_W0 = 32'h1122_3344;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              st    [ND];
    logic [ADDR_W-1:0] ma_in [ND];
    logic              rdy   [ND];
    logic              v     [ND];
    logic              lst   [ND];
    logic              dn    [ND];
    logic              we    [ND];
    logic              mc    [ND];
    logic [511:0]      d     [ND];
    logic [5:0]        ix    [ND];
    logic [ADDR_W-1:0] ma_o  [ND];
    logic [31:0]       mem   [65536];
    int                n_chk  = 0;
    int                n_pass = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    sha256_block_loader_if #(.ADDR_W(ADDR_W)) bus [ND] ();

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sha256_block_loader #(.NUM_OF_WORDS(NW[g]), .ADDR_W(ADDR_W)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (st[g]),
            .message_addr(ma_in[g]),
            .done        (dn[g]),
            .bus         (bus[g])
        );
        always_ff @(posedge clk) bus[g].mem_read_data <= mem[bus[g].mem_addr];
        assign bus[g].blk_ready = rdy[g];
        assign v[g]    = bus[g].blk_valid;
        assign lst[g]  = bus[g].blk_last;
        assign we[g]   = bus[g].mem_we;
        assign mc[g]   = bus[g].mem_clk;
        assign d[g]    = bus[g].blk_data;
        assign ix[g]   = bus[g].blk_idx;
        assign ma_o[g] = bus[g].mem_addr;
    end

    function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef SHA256_BYTE_SWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] exp_word(input int k, input int p);
        int n  = int'(NW[k]);
        int nb = (n + 2) / 16 + 1;
        if (p < n)              return sw(mem[ADDR_W'(int'(BASE[k]) + p)]);
        else if (p == n)        return 32'h8000_0000;
        else if (p == 16*nb-1)  return 32'(32 * n);
        else                    return 32'h0;
    endfunction

    function automatic logic [511:0] blk_exp(input int k, input int b);
        logic [511:0] r = '0;
        for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = exp_word(k, b*16 + i);
        return r;
    endfunction

    function automatic logic [31:0] wd(input logic [511:0] b, input int i);
        return b[511 - 32*i -: 32];
    endfunction

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int k, input logic [ADDR_W-1:0] a);
        @(negedge clk);
        ma_in[k] = a;
        st[k]    = 1'b1;
        @(negedge clk);
        st[k]    = 1'b0;
    endtask

    // cyc counts the start cycle as cycle 0 and returns the cycle where blk_valid is first seen
    task automatic wait_valid(input int k, output int cyc);
        cyc = 1;
        do begin
            @(negedge clk);
            cyc++;
        end while (!v[k] && cyc < 400);
        if (!v[k]) chk("valid_timeout", 576'(v[k]), 576'(1'b1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int                cyc;
        int                ns;
        logic [511:0]      snap;
        logic [ADDR_W-1:0] prev;
        logic [ADDR_W-1:0] seen [8];

        reset = 1'b1;
        for (int k = 0; k < ND; k++) begin
            st[k] = 1'b0; ma_in[k] = '0; rdy[k] = 1'b1;
        end
        for (int i = 0; i < 20; i++) mem[ADDR_W'(32'h100 + i)] = 32'(i + 1);
        mem[16'hFFFE] = 32'h1122_3344;
        mem[16'hFFFF] = 32'h5566_7788;
        mem[16'h0000] = 32'h99AA_BBCC;
        mem[16'h0001] = 32'hDDEE_FF00;
        for (int i = 0; i < 8; i++) seen[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", 576'({v[0], lst[0], ix[0], d[0], ma_o[0], dn[0]}),
            576'({1'b0, 1'b0, 6'd0, 512'd0, 16'd0, 1'b1}));
        chk("rst_done_we", 576'({dn[1], dn[2], dn[3], we[0], we[1], we[2], we[3]}), 576'(7'b1110000));
        @(negedge clk);
        reset = 1'b0;
        chk("mem_clk_lo", 576'({mc[0], mc[1], mc[2], mc[3]}), 576'(4'b0000));
        @(posedge clk);
        #1;
        chk("mem_clk_hi", 576'({mc[0], mc[1], mc[2], mc[3]}), 576'(4'b1111));

        // N=20, two blocks, consumer always ready
        do_start(0, 16'h0100);
        chk("n20_busy", 576'(dn[0]), 576'(1'b0));
        wait_valid(0, cyc);
        chk("n20_latency", 576'(cyc), 576'(49));
        chk("n20_blk0", 576'(d[0]), 576'(blk_exp(0, 0)));
        chk("n20_blk0_w0_w15", 576'({wd(d[0], 0), wd(d[0], 15)}), 576'({sw(32'd1), sw(32'd16)}));
        chk("n20_blk0_idx_last", 576'({ix[0], lst[0]}), 576'({6'd0, 1'b0}));
        wait_valid(0, cyc);
        chk("n20_blk1", 576'(d[0]), 576'({sw(32'd17), sw(32'd18), sw(32'd19), sw(32'd20),
                                          32'h8000_0000, 320'h0, 32'd640}));
        chk("n20_blk1_idx_last", 576'({ix[0], lst[0]}), 576'({6'd1, 1'b1}));
        @(negedge clk);
        chk("n20_done", 576'({dn[0], v[0]}), 576'({1'b1, 1'b0}));

        // N=13, single block; start overlapping the last handshake is ignored, then taken in IDLE
        do_start(1, 16'h0100);
        wait_valid(1, cyc);
        chk("n13_blk0", 576'(d[1]), 576'(blk_exp(1, 0)));
        chk("n13_pad", 576'({wd(d[1], 12), wd(d[1], 13), wd(d[1], 14), wd(d[1], 15)}),
            576'({sw(32'd13), 32'h8000_0000, 32'h0, 32'h0000_01A0}));
        chk("n13_idx_last", 576'({ix[1], lst[1]}), 576'({6'd0, 1'b1}));
        st[1] = 1'b1;
        @(negedge clk);
        chk("n13_start_ignored", 576'({dn[1], v[1], ma_o[1]}), 576'({1'b1, 1'b0, 16'h010C}));
        @(negedge clk);
        st[1] = 1'b0;
        chk("n13_start_resampled", 576'({dn[1], ma_o[1]}), 576'({1'b0, 16'h0100}));
        wait_valid(1, cyc);
        chk("n13_rerun_blk0", 576'(d[1]), 576'(blk_exp(1, 0)));
        @(negedge clk);
        chk("n13_rerun_done", 576'(dn[1]), 576'(1'b1));

        // N=14: length spills into a second, all-pad block
        do_start(2, 16'h0100);
        wait_valid(2, cyc);
        chk("n14_blk0_tail", 576'({wd(d[2], 13), wd(d[2], 14), wd(d[2], 15), lst[2]}),
            576'({sw(32'd14), 32'h8000_0000, 32'h0, 1'b0}));
        wait_valid(2, cyc);
        chk("n14_blk1", 576'({d[2], ix[2], lst[2]}), 576'({480'h0, 32'd448, 6'd1, 1'b1}));

        // N=4 at 0xFFFE: address wrap
        prev = ma_o[3];
        ns   = 0;
        @(negedge clk);
        ma_in[3] = 16'hFFFE;
        st[3]    = 1'b1;
        cyc      = 0;
        do begin
            @(negedge clk);
            st[3] = 1'b0;
            cyc++;
            if (ma_o[3] !== prev) begin
                if (ns < 8) seen[ns] = ma_o[3];
                ns++;
                prev = ma_o[3];
            end
        end while (!v[3] && cyc < 300);
        chk("wrap_valid", 576'(v[3]), 576'(1'b1));
        chk("wrap_addr_seq", 576'({32'(ns), seen[0], seen[1], seen[2], seen[3]}),
            576'({32'd4, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001}));
        chk("wrap_w0", 576'(wd(d[3], 0)), 576'(WRAP_W0));
        chk("wrap_blk0", 576'({d[3], ix[3], lst[3]}), 576'({blk_exp(3, 0), 6'd0, 1'b1}));
        chk("wrap_len", 576'({wd(d[3], 4), wd(d[3], 15)}), 576'({32'h8000_0000, 32'd128}));

        // Backpressure on N=20 block 0
        rdy[0] = 1'b0;
        do_start(0, 16'h0100);
        wait_valid(0, cyc);
        snap = d[0];
        chk("bp_blk0", 576'({snap, ma_o[0]}), 576'({blk_exp(0, 0), 16'h010F}));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_hold", 576'({v[0], ix[0], ma_o[0], d[0]}), 576'({1'b1, 6'd0, 16'h010F, snap}));
        end
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("bp_accept_resume", 576'({v[0], ma_o[0]}), 576'({1'b0, 16'h0110}));
        wait_valid(0, cyc);
        chk("bp_blk1", 576'({d[0], ix[0], lst[0]}), 576'({blk_exp(0, 1), 6'd1, 1'b1}));
        @(negedge clk);

        // Reset during word 7 of block 0, then a clean rerun ignoring start in OUT
        rdy[0] = 1'b0;
        do_start(0, 16'h0100);
        cyc = 0;
        while (ma_o[0] !== 16'h0107 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_reach_w7", 576'({ma_o[0], we[0]}), 576'({16'h0107, 1'b0}));
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_abort", 576'({v[0], dn[0], d[0]}), 576'({1'b0, 1'b1, 512'd0}));
        reset = 1'b0;
        do_start(0, 16'h0100);
        wait_valid(0, cyc);
        chk("rerun_blk0", 576'({d[0], ix[0], lst[0]}), 576'({blk_exp(0, 0), 6'd0, 1'b0}));
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        chk("start_in_out_ignored", 576'({v[0], ix[0], ma_o[0], d[0]}),
            576'({1'b1, 6'd0, 16'h010F, blk_exp(0, 0)}));
        rdy[0] = 1'b1;
        wait_valid(0, cyc);
        chk("rerun_blk1", 576'({d[0], ix[0], lst[0]}), 576'({blk_exp(0, 1), 6'd1, 1'b1}));
        @(negedge clk);
        chk("rerun_done", 576'(dn[0]), 576'(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
